// File: rtl/qp_dsp_pkg.sv
// Shared DSP package: DDC sample types and the I/Q integrator state/width helpers.
package qp_dsp_pkg;

    // DDC output sample width; the integrator input width follows it.
    localparam int DDC_OUT_WIDTH = 24;

    // One DDC output beat.
    typedef struct packed {
        logic                            valid;
        logic signed [DDC_OUT_WIDTH-1:0] data_i;
        logic signed [DDC_OUT_WIDTH-1:0] data_q;
    } ddc_sample_t;

    // Integrator measurement states.
    typedef enum logic [1:0] {
        INT_IDLE,
        INT_DELAY,
        INT_INTEGRATE,
        INT_DONE
    } int_state_t;

    // Accumulator width that holds max_window full-scale samples without wrap.
    function automatic int int_acc_width(input int in_width, input int max_window);
        return in_width + $clog2(max_window);
    endfunction

endpackage

// File: rtl/iq_integrator.sv
// Triggered, gated I/Q integrator placed directly downstream of the DDC.
// A trigger latches the shadow config, skips 'delay' valid samples and then
// sums 'window+1' valid samples; the result is strobed for one cycle.
module iq_integrator
    import qp_dsp_pkg::*;
#(
    parameter int  INT_IN_DATA_WIDTH = 24,
    parameter int  INT_MAX_WINDOW    = 1024,
    parameter int  INT_MAX_DELAY     = 256,
    localparam int INT_ACC_WIDTH     = int_acc_width(INT_IN_DATA_WIDTH, INT_MAX_WINDOW),
    localparam int DLY_W             = $clog2(INT_MAX_DELAY),
    localparam int WIN_W             = $clog2(INT_MAX_WINDOW)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                i_valid,
    input  logic signed [INT_IN_DATA_WIDTH-1:0] i_data_i,
    input  logic signed [INT_IN_DATA_WIDTH-1:0] i_data_q,
    input  logic                                i_trig,
    input  logic                                i_cfg_valid,
    input  logic        [DLY_W-1:0]             i_cfg_delay,
    input  logic        [WIN_W-1:0]             i_cfg_window,
    output logic                                o_valid,
    output logic signed [INT_ACC_WIDTH-1:0]     o_sum_i,
    output logic signed [INT_ACC_WIDTH-1:0]     o_sum_q,
    output logic                                o_busy,
    output logic                                o_trig_miss
);

    // One counter serves both the delay and the window phase.
    localparam int CNT_W = (WIN_W > DLY_W) ? WIN_W : DLY_W;
    localparam int EXT_W = INT_ACC_WIDTH - INT_IN_DATA_WIDTH;

    int_state_t state_reg, state_next;

    logic [DLY_W-1:0] shadow_delay_reg, act_delay_reg;
    logic [WIN_W-1:0] shadow_window_reg, act_window_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             trig_miss_reg;

    logic delay_last;
    logic win_last;

    // Channel 0 is I, channel 1 is Q; both accumulators are the same logic.
    logic signed [INT_IN_DATA_WIDTH-1:0] data_ch [2];
    logic signed [INT_ACC_WIDTH-1:0]     acc_reg [2];
    logic signed [INT_ACC_WIDTH-1:0]     sum_reg [2];

    assign data_ch[0] = i_data_i;
    assign data_ch[1] = i_data_q;

    assign delay_last = (cnt_reg == CNT_W'(act_delay_reg - DLY_W'(1)));
    assign win_last   = (cnt_reg == CNT_W'(act_window_reg));

    assign o_valid     = (state_reg == INT_DONE);
    assign o_busy      = (state_reg != INT_IDLE);
    assign o_trig_miss = trig_miss_reg;
    assign o_sum_i     = sum_reg[0];
    assign o_sum_q     = sum_reg[1];

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= INT_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; the delay-0 shortcut looks at the shadow value being latched.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            INT_IDLE: begin
                if (i_trig) begin
                    state_next = (shadow_delay_reg == '0) ? INT_INTEGRATE : INT_DELAY;
                end
            end
            INT_DELAY: begin
                if (i_valid && delay_last) begin
                    state_next = INT_INTEGRATE;
                end
            end
            INT_INTEGRATE: begin
                if (i_valid && win_last) begin
                    state_next = INT_DONE;
                end
            end
            INT_DONE: begin
                state_next = INT_IDLE;
            end
            default: begin
                state_next = INT_IDLE;
            end
        endcase
    end

    // Config shadow/active registers, sample counter and trigger-miss pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            shadow_delay_reg  <= '0;
            shadow_window_reg <= WIN_W'(INT_MAX_WINDOW - 1);
            act_delay_reg     <= '0;
            act_window_reg    <= WIN_W'(INT_MAX_WINDOW - 1);
            cnt_reg           <= '0;
            trig_miss_reg     <= 1'b0;
        end else begin
            trig_miss_reg <= i_trig && (state_reg != INT_IDLE);
            if (i_cfg_valid) begin
                shadow_delay_reg  <= i_cfg_delay;
                shadow_window_reg <= i_cfg_window;
            end
            case (state_reg)
                INT_IDLE: begin
                    if (i_trig) begin
                        act_delay_reg  <= shadow_delay_reg;
                        act_window_reg <= shadow_window_reg;
                        cnt_reg        <= '0;
                    end
                end
                INT_DELAY: begin
                    if (i_valid) begin
                        cnt_reg <= delay_last ? '0 : cnt_reg + CNT_W'(1);
                    end
                end
                INT_INTEGRATE: begin
                    if (i_valid) begin
                        cnt_reg <= win_last ? '0 : cnt_reg + CNT_W'(1);
                    end
                end
                default: begin
                    cnt_reg <= '0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_acc
        logic signed [INT_ACC_WIDTH-1:0] ext;
        logic signed [INT_ACC_WIDTH-1:0] acc_next;

        assign ext      = {{EXT_W{data_ch[gi][INT_IN_DATA_WIDTH-1]}}, data_ch[gi]};
        // The first sample of a window overwrites the accumulator.
        assign acc_next = (cnt_reg == '0) ? ext : acc_reg[gi] + ext;

        // Accumulate valid samples and capture the total on the last one.
        always_ff @(posedge clk) begin
            if (!rst) begin
                acc_reg[gi] <= '0;
                sum_reg[gi] <= '0;
            end else if (state_reg == INT_INTEGRATE && i_valid) begin
                acc_reg[gi] <= acc_next;
                if (win_last) begin
                    sum_reg[gi] <= acc_next;
                end
            end
        end
    end

endmodule
